rob_buffer: RTL and testbench

Reorder buffer at the receiving end of the ROB completion bus driven by the daisy-chained functional-unit output stages. It allocates entries in program order at dispatch and captures out-of-order completion writes (robid, flags, wbs, value). It retires entries in order through a commit handshake and offers a combinational operand-lookup port for dispatch.

---
 rtl/rob_pkg.sv | 27 ++
 rtl/rob_entry_array.sv | 93 +++++++++
 rtl/rob_buffer.sv | 121 ++++++++++++
 tb/tb_rob_buffer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// ============================================================================
// rob_pkg
// Shared widths and entry record for the reorder buffer and its storage.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rob_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int ROBID_W   = 4;
    localparam int CNT_W     = 5;
    localparam int FLAGS_W   = 8;
    localparam int WBS_W     = 8;
    localparam int VAL_W     = 8;

    typedef struct packed {
        logic               valid;
        logic               done;
        logic [WBS_W-1:0]   wbs;
        logic [FLAGS_W-1:0] flags;
        logic [VAL_W-1:0]   value;
    } rob_entry_t;

endpackage

`default_nettype wire

// File: rtl/rob_entry_array.sv
// ============================================================================
// rob_entry_array
// ROB entry storage: alloc/completion write ports, commit clear, head and
// lookup read ports.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rob_entry_array
    import rob_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_flush,
    input  logic               i_alloc_en,
    input  logic [ROBID_W-1:0] i_alloc_idx,
    input  logic [WBS_W-1:0]   i_alloc_wbs,
    input  logic               i_cmpl_en,
    input  logic [ROBID_W-1:0] i_cmpl_idx,
    input  logic [FLAGS_W-1:0] i_cmpl_flags,
    input  logic [WBS_W-1:0]   i_cmpl_wbs,
    input  logic [VAL_W-1:0]   i_cmpl_value,
    input  logic               i_clr_en,
    input  logic [ROBID_W-1:0] i_clr_idx,
    input  logic [ROBID_W-1:0] i_head_idx,
    input  logic [ROBID_W-1:0] i_lkup_idx,
    output rob_entry_t         o_head,
    output logic               o_lkup_done,
    output logic [VAL_W-1:0]   o_lkup_value,
    output logic               o_cmpl_accept
);

    logic [ROB_DEPTH-1:0] r_valid;
    logic [ROB_DEPTH-1:0] r_done;
    logic [WBS_W-1:0]     r_wbs   [ROB_DEPTH];
    logic [FLAGS_W-1:0]   r_flags [ROB_DEPTH];
    logic [VAL_W-1:0]     r_value [ROB_DEPTH];

    logic w_cmpl_accept;
    logic w_cmpl_wr;

    // A completion only lands on an allocated entry that has not finished yet.
    assign w_cmpl_accept = i_cmpl_en & r_valid[i_cmpl_idx] & ~r_done[i_cmpl_idx];
    assign w_cmpl_wr     = w_cmpl_accept & ~i_flush;
    assign o_cmpl_accept = w_cmpl_accept;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            if (i_alloc_en) begin
                r_valid[i_alloc_idx] <= 1'b1;
                r_done[i_alloc_idx]  <= 1'b0;
            end
            if (w_cmpl_wr) begin
                r_done[i_cmpl_idx] <= 1'b1;
            end
            if (i_clr_en) begin
                r_valid[i_clr_idx] <= 1'b0;
                r_done[i_clr_idx]  <= 1'b0;
            end
        end
    end

    // Payload is always qualified by valid/done, so it carries no reset.
    always_ff @(posedge clk) begin
        if (!i_flush) begin
            if (i_alloc_en) begin
                r_wbs[i_alloc_idx] <= i_alloc_wbs;
            end
            if (w_cmpl_wr) begin
                r_wbs[i_cmpl_idx]   <= i_cmpl_wbs;
                r_flags[i_cmpl_idx] <= i_cmpl_flags;
                r_value[i_cmpl_idx] <= i_cmpl_value;
            end
        end
    end

    always_comb begin
        o_head.valid = r_valid[i_head_idx];
        o_head.done  = r_done[i_head_idx];
        o_head.wbs   = r_wbs[i_head_idx];
        o_head.flags = r_flags[i_head_idx];
        o_head.value = r_value[i_head_idx];
    end

    assign o_lkup_done  = r_valid[i_lkup_idx] & r_done[i_lkup_idx];
    assign o_lkup_value = r_value[i_lkup_idx];

endmodule

`default_nettype wire

// File: rtl/rob_buffer.sv
// ============================================================================
// rob_buffer
// In-order reorder buffer: allocation, out-of-order completion capture,
// in-order commit handshake and combinational operand lookup.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rob_buffer
    import rob_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               alloc_req,
    input  logic [WBS_W-1:0]   alloc_wbs,
    output logic               alloc_ready,
    output logic [ROBID_W-1:0] alloc_robid,
    input  logic               rob_valid,
    input  logic [ROBID_W-1:0] rob_robid,
    input  logic [FLAGS_W-1:0] rob_flags,
    input  logic [WBS_W-1:0]   rob_wbs,
    input  logic [VAL_W-1:0]   rob_value,
    output logic               commit_valid,
    input  logic               commit_ready,
    output logic [ROBID_W-1:0] commit_robid,
    output logic [WBS_W-1:0]   commit_wbs,
    output logic [FLAGS_W-1:0] commit_flags,
    output logic [VAL_W-1:0]   commit_value,
    input  logic [ROBID_W-1:0] lookup_robid,
    output logic               lookup_done,
    output logic [VAL_W-1:0]   lookup_value,
    output logic [CNT_W-1:0]   count,
    output logic               err_spurious
);

    localparam logic [CNT_W-1:0] c_FULL_COUNT = CNT_W'(ROB_DEPTH);

    logic [ROBID_W-1:0] r_head;
    logic [ROBID_W-1:0] r_tail;
    logic [CNT_W-1:0]   r_count;
    logic               r_err;

    rob_entry_t         w_head;
    logic               w_lkup_done;
    logic [VAL_W-1:0]   w_lkup_value;
    logic               w_cmpl_accept;
    logic               w_alloc;
    logic               w_commit;
    logic               w_spurious;

    assign alloc_ready  = (r_count != c_FULL_COUNT);
    assign w_alloc      = alloc_req & alloc_ready & ~flush;
    assign commit_valid = w_head.valid & w_head.done;
    assign w_commit     = commit_valid & commit_ready & ~flush;
    assign w_spurious   = rob_valid & ~w_cmpl_accept & ~flush;

    rob_entry_array u_entries (
        .clk           (clk),
        .rst           (rst),
        .i_flush       (flush),
        .i_alloc_en    (w_alloc),
        .i_alloc_idx   (r_tail),
        .i_alloc_wbs   (alloc_wbs),
        .i_cmpl_en     (rob_valid),
        .i_cmpl_idx    (rob_robid),
        .i_cmpl_flags  (rob_flags),
        .i_cmpl_wbs    (rob_wbs),
        .i_cmpl_value  (rob_value),
        .i_clr_en      (w_commit),
        .i_clr_idx     (r_head),
        .i_head_idx    (r_head),
        .i_lkup_idx    (lookup_robid),
        .o_head        (w_head),
        .o_lkup_done   (w_lkup_done),
        .o_lkup_value  (w_lkup_value),
        .o_cmpl_accept (w_cmpl_accept)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (flush) begin
            // Flush keeps the sticky error so software can still observe it.
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_alloc) begin
                r_tail <= r_tail + ROBID_W'(1);
            end
            if (w_commit) begin
                r_head <= r_head + ROBID_W'(1);
            end
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_spurious) begin
                r_err <= 1'b1;
            end
        end
    end

    assign alloc_robid  = r_tail;
    assign commit_robid = r_head;
    assign commit_wbs   = w_head.wbs;
    assign commit_flags = w_head.flags;
    assign commit_value = w_head.value;
    assign lookup_done  = w_lkup_done;
    assign lookup_value = w_lkup_done ? w_lkup_value : '0;
    assign count        = r_count;
    assign err_spurious = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rob_buffer.sv
// ============================================================================
// tb_rob_buffer
// Directed vector table plus hand sequences for the reorder buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rob_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       alloc_req;
    logic [7:0] alloc_wbs;
    logic       alloc_ready;
    logic [3:0] alloc_robid;
    logic       rob_valid;
    logic [3:0] rob_robid;
    logic [7:0] rob_flags;
    logic [7:0] rob_wbs;
    logic [7:0] rob_value;
    logic       commit_valid;
    logic       commit_ready;
    logic [3:0] commit_robid;
    logic [7:0] commit_wbs;
    logic [7:0] commit_flags;
    logic [7:0] commit_value;
    logic [3:0] lookup_robid;
    logic       lookup_done;
    logic [7:0] lookup_value;
    logic [4:0] count;
    logic       err_spurious;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rob_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .alloc_req    (alloc_req),
        .alloc_wbs    (alloc_wbs),
        .alloc_ready  (alloc_ready),
        .alloc_robid  (alloc_robid),
        .rob_valid    (rob_valid),
        .rob_robid    (rob_robid),
        .rob_flags    (rob_flags),
        .rob_wbs      (rob_wbs),
        .rob_value    (rob_value),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .commit_robid (commit_robid),
        .commit_wbs   (commit_wbs),
        .commit_flags (commit_flags),
        .commit_value (commit_value),
        .lookup_robid (lookup_robid),
        .lookup_done  (lookup_done),
        .lookup_value (lookup_value),
        .count        (count),
        .err_spurious (err_spurious)
    );

    typedef struct {
        logic       areq;
        logic [7:0] awbs;
        logic       rv;
        logic [3:0] rid;
        logic [7:0] rfl;
        logic [7:0] rwbs;
        logic [7:0] rval;
        logic       cr;
        logic [3:0] lrid;
        logic       e_ar;
        logic [3:0] e_arid;
        logic       e_cv;
        logic [3:0] e_crid;
        logic [7:0] e_cwbs;
        logic [7:0] e_cfl;
        logic [7:0] e_cval;
        logic [4:0] e_cnt;
        logic       e_err;
        logic       e_ld;
        logic [7:0] e_lv;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        flush        = 1'b0;
        alloc_req    = 1'b0;
        alloc_wbs    = 8'h00;
        rob_valid    = 1'b0;
        rob_robid    = 4'h0;
        rob_flags    = 8'h00;
        rob_wbs      = 8'h00;
        rob_value    = 8'h00;
        commit_ready = 1'b0;
        lookup_robid = 4'h0;
    endtask

    task automatic complete(input logic [3:0] rid, input logic [7:0] fl,
                            input logic [7:0] wbs, input logic [7:0] val);
        rob_valid = 1'b1;
        rob_robid = rid;
        rob_flags = fl;
        rob_wbs   = wbs;
        rob_value = val;
    endtask

    initial begin
        // Inputs applied before the edge; expectations are the pre-edge outputs.
        //            areq awbs  rv rid rfl    rwbs   rval   cr lrid | ar arid cv crid cwbs   cfl    cval   cnt err ld lv
        vecs[0]  = '{0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00};
        vecs[1]  = '{1, 8'h01, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00};
        vecs[2]  = '{1, 8'h02, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h00};
        vecs[3]  = '{1, 8'h03, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 2, 0, 0, 8'h00, 8'h00, 8'h00, 2, 0, 0, 8'h00};
        vecs[4]  = '{0, 8'h00, 1, 0, 8'h01, 8'h01, 8'h5A, 0, 0, 1, 3, 0, 0, 8'h00, 8'h00, 8'h00, 3, 0, 0, 8'h00};
        vecs[5]  = '{0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 3, 1, 0, 8'h01, 8'h01, 8'h5A, 3, 0, 1, 8'h5A};
        vecs[6]  = '{0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 1, 3, 1, 0, 8'h01, 8'h01, 8'h5A, 3, 0, 1, 8'h5A};
        vecs[7]  = '{0, 8'h00, 1, 2, 8'h02, 8'h12, 8'h22, 1, 0, 1, 3, 0, 0, 8'h00, 8'h00, 8'h00, 2, 0, 0, 8'h00};
        vecs[8]  = '{0, 8'h00, 1, 1, 8'h00, 8'h11, 8'h11, 1, 2, 1, 3, 0, 0, 8'h00, 8'h00, 8'h00, 2, 0, 1, 8'h22};
        vecs[9]  = '{0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 1, 3, 1, 1, 8'h11, 8'h00, 8'h11, 2, 0, 1, 8'h11};
        vecs[10] = '{0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 1, 2, 1, 3, 1, 2, 8'h12, 8'h02, 8'h22, 1, 0, 1, 8'h22};
        vecs[11] = '{0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 1, 2, 1, 3, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00};

        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            alloc_req    = vecs[i].areq;
            alloc_wbs    = vecs[i].awbs;
            rob_valid    = vecs[i].rv;
            rob_robid    = vecs[i].rid;
            rob_flags    = vecs[i].rfl;
            rob_wbs      = vecs[i].rwbs;
            rob_value    = vecs[i].rval;
            commit_ready = vecs[i].cr;
            lookup_robid = vecs[i].lrid;
            #1;
            chk($sformatf("v%0d alloc_ready", i), 32'(alloc_ready), 32'(vecs[i].e_ar));
            chk($sformatf("v%0d alloc_robid", i), 32'(alloc_robid), 32'(vecs[i].e_arid));
            chk($sformatf("v%0d commit_valid", i), 32'(commit_valid), 32'(vecs[i].e_cv));
            chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d err_spurious", i), 32'(err_spurious), 32'(vecs[i].e_err));
            chk($sformatf("v%0d lookup_done", i), 32'(lookup_done), 32'(vecs[i].e_ld));
            chk($sformatf("v%0d lookup_value", i), 32'(lookup_value), 32'(vecs[i].e_lv));
            if (vecs[i].e_cv) begin
                chk($sformatf("v%0d commit_robid", i), 32'(commit_robid), 32'(vecs[i].e_crid));
                chk($sformatf("v%0d commit_wbs", i), 32'(commit_wbs), 32'(vecs[i].e_cwbs));
                chk($sformatf("v%0d commit_flags", i), 32'(commit_flags), 32'(vecs[i].e_cfl));
                chk($sformatf("v%0d commit_value", i), 32'(commit_value), 32'(vecs[i].e_cval));
            end
            @(negedge clk);
        end

        // Spurious completions: unallocated robid 7, then a repeat to a done entry.
        idle();
        complete(4'd7, 8'h0F, 8'h0F, 8'hEE);
        @(negedge clk);
        idle();
        lookup_robid = 4'd7;
        #1;
        chk("spur unalloc err", 32'(err_spurious), 32'd1);
        chk("spur unalloc ld", 32'(lookup_done), 32'd0);
        chk("spur unalloc lv", 32'(lookup_value), 32'd0);
        alloc_req = 1'b1;
        alloc_wbs = 8'h30;
        #1;
        chk("spur alloc robid", 32'(alloc_robid), 32'd3);
        @(negedge clk);
        idle();
        complete(4'd3, 8'h03, 8'h30, 8'h33);
        @(negedge clk);
        complete(4'd3, 8'hFF, 8'hFF, 8'h99);
        lookup_robid = 4'd3;
        #1;
        chk("spur first lv", 32'(lookup_value), 32'h33);
        @(negedge clk);
        idle();
        lookup_robid = 4'd3;
        #1;
        chk("spur repeat lv", 32'(lookup_value), 32'h33);
        chk("spur repeat err", 32'(err_spurious), 32'd1);
        chk("spur head value", 32'(commit_value), 32'h33);
        commit_ready = 1'b1;
        @(negedge clk);
        idle();
        #1;
        chk("spur drained count", 32'(count), 32'd0);
        chk("spur sticky err", 32'(err_spurious), 32'd1);

        // Flush with 5 outstanding and a same-cycle alloc, completion and commit.
        alloc_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            alloc_wbs = 8'(8'h50 + i);
            @(negedge clk);
        end
        idle();
        complete(4'd4, 8'h00, 8'h50, 8'h44);
        @(negedge clk);
        idle();
        #1;
        chk("pre-flush count", 32'(count), 32'd5);
        chk("pre-flush cv", 32'(commit_valid), 32'd1);
        flush        = 1'b1;
        alloc_req    = 1'b1;
        commit_ready = 1'b1;
        complete(4'd5, 8'h00, 8'h51, 8'h55);
        @(negedge clk);
        idle();
        lookup_robid = 4'd5;
        #1;
        chk("flush count", 32'(count), 32'd0);
        chk("flush cv", 32'(commit_valid), 32'd0);
        chk("flush alloc_robid", 32'(alloc_robid), 32'd0);
        chk("flush alloc_ready", 32'(alloc_ready), 32'd1);
        chk("flush err kept", 32'(err_spurious), 32'd1);
        chk("flush lookup5 ld", 32'(lookup_done), 32'd0);

        // Fill all 16, then free the head while alloc_req is held.
        alloc_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            alloc_wbs = 8'(8'h40 + i);
            #1;
            chk($sformatf("fill robid %0d", i), 32'(alloc_robid), 32'(i));
            @(negedge clk);
        end
        #1;
        chk("full count", 32'(count), 32'd16);
        chk("full alloc_ready", 32'(alloc_ready), 32'd0);
        complete(4'd0, 8'h00, 8'h40, 8'hA0);
        @(negedge clk);
        rob_valid = 1'b0;
        #1;
        chk("full held count", 32'(count), 32'd16);
        chk("full head cv", 32'(commit_valid), 32'd1);
        commit_ready = 1'b1;
        @(negedge clk);
        commit_ready = 1'b0;
        #1;
        chk("after commit count", 32'(count), 32'd15);
        chk("after commit ready", 32'(alloc_ready), 32'd1);
        chk("wrap alloc_robid", 32'(alloc_robid), 32'd0);
        @(negedge clk);
        idle();
        #1;
        chk("refill count", 32'(count), 32'd16);
        chk("refill ready", 32'(alloc_ready), 32'd0);
        chk("refill tail", 32'(alloc_robid), 32'd1);

        // Backpressure on a done head.
        complete(4'd1, 8'h07, 8'h5B, 8'h77);
        @(negedge clk);
        idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp%0d cv", i), 32'(commit_valid), 32'd1);
            chk($sformatf("bp%0d robid", i), 32'(commit_robid), 32'd1);
            chk($sformatf("bp%0d value", i), 32'(commit_value), 32'h77);
            chk($sformatf("bp%0d flags", i), 32'(commit_flags), 32'h07);
            chk($sformatf("bp%0d wbs", i), 32'(commit_wbs), 32'h5B);
            @(negedge clk);
        end
        commit_ready = 1'b1;
        @(negedge clk);
        commit_ready = 1'b0;
        #1;
        chk("bp single commit count", 32'(count), 32'd15);
        chk("bp head advanced", 32'(commit_robid), 32'd2);
        chk("bp next cv", 32'(commit_valid), 32'd0);

        // Reset mid-operation also clears the sticky error.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst count", 32'(count), 32'd0);
        chk("rst err", 32'(err_spurious), 32'd0);
        chk("rst cv", 32'(commit_valid), 32'd0);
        chk("rst alloc_ready", 32'(alloc_ready), 32'd1);
        chk("rst alloc_robid", 32'(alloc_robid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
